// File: rtl/line_data_memory.sv
// Block-granular backing memory answering one full-line read or write per request
// after a fixed latency; sits below the cache's miss/writeback FSM.
module line_data_memory #(
  parameter int BLOCK_SIZE = 16,
  parameter int NUM_LINES  = 1024,
  parameter int LATENCY    = 50
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      is_input_valid,
  input  logic [31:0]               addr,
  input  logic                      mem_read,
  input  logic                      mem_write,
  input  logic [8*BLOCK_SIZE-1:0]   din,
  output logic                      is_output_valid,
  output logic [8*BLOCK_SIZE-1:0]   dout,
  output logic                      mem_ready
);

  localparam int LINE_W = 8 * BLOCK_SIZE;
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int CNT_W  = $clog2(LATENCY) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic                     op_write_p0;
  logic [IDX_W-1:0]         idx_p0;
  logic signed [LINE_W-1:0] din_p0;
  logic                     accept;
  logic                     commit;
  logic                     unused_addr;

  // Contents start at zero and survive reset.
  logic [LINE_W-1:0] mem [NUM_LINES] = '{default: '0};

  // Requests with both or neither op bit set are silently ignored.
  assign accept      = is_input_valid && (mem_read ^ mem_write);
  assign commit      = (state == BUSY) && (cnt == '0);
  assign mem_ready   = (state != BUSY);
  assign unused_addr = ^addr[31:IDX_W];

  // Stage p0: request latched at accept; requester is free to change its inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      dout            <= '0;
      is_output_valid <= 1'b0;
    end else begin
      is_output_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            op_write_p0 <= mem_write;
            idx_p0      <= addr[IDX_W-1:0];
            din_p0      <= din;
            cnt         <= CNT_LOAD;
            state       <= BUSY;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state <= DONE;
            if (!op_write_p0) begin
              dout            <= mem[idx_p0];
              is_output_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write commits on the same edge BUSY ends; a reset on that edge drops it.
  always_ff @(posedge clk) begin
    if (!reset && commit && op_write_p0)
      mem[idx_p0] <= din_p0;
  end

endmodule

// File: tb/tb_line_data_memory.sv
// Directed bench for line_data_memory: transaction-level reference model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_line_data_memory;

  localparam int BS  = 16;
  localparam int NL  = 16;
  localparam int LAT = 4;
  localparam int W   = 8 * BS;

  logic          clk = 1'b0;
  logic          reset;
  logic          is_input_valid;
  logic [31:0]   addr;
  logic          mem_read;
  logic          mem_write;
  logic [W-1:0]  din;
  logic          is_output_valid;
  logic [W-1:0]  dout;
  logic          mem_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  line_data_memory #(.BLOCK_SIZE(BS), .NUM_LINES(NL), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .is_input_valid(is_input_valid), .addr(addr),
    .mem_read(mem_read), .mem_write(mem_write), .din(din),
    .is_output_valid(is_output_valid), .dout(dout), .mem_ready(mem_ready)
  );

  task automatic check_v(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Reference model: an accepted request completes LAT edges later.
  logic [W-1:0] mmem [NL];
  logic         m_started = 1'b0;
  logic         m_busy    = 1'b0;
  logic         m_wr;
  int           m_acc_edge;
  int           m_idx;
  int           edge_no = 0;
  logic [W-1:0] m_din;
  logic [W-1:0] e_dout;
  logic         e_pulse;
  logic         e_ready;

  initial for (int i = 0; i < NL; i++) mmem[i] = '0;

  always @(posedge clk) begin
    edge_no++;
    if (reset) begin
      m_started = 1'b1;
      m_busy    = 1'b0;
      e_dout    = '0;
      e_pulse   = 1'b0;
      e_ready   = 1'b1;
    end else begin
      e_pulse = 1'b0;
      if (m_busy && edge_no == m_acc_edge + LAT) begin
        m_busy = 1'b0;
        if (m_wr) mmem[m_idx] = m_din;
        else begin
          e_dout  = mmem[m_idx];
          e_pulse = 1'b1;
        end
      end else if (!m_busy && is_input_valid && (mem_read != mem_write)) begin
        m_busy     = 1'b1;
        m_acc_edge = edge_no;
        m_wr       = mem_write;
        m_idx      = int'(addr % 32'(NL));
        m_din      = din;
      end
      e_ready = !m_busy;
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      check_i("cmp_ready", int'(mem_ready), int'(e_ready));
      check_i("cmp_valid", int'(is_output_valid), int'(e_pulse));
      check_v("cmp_dout", dout, e_dout);
    end
  end

  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [W-1:0] d, output int busy, output logic pulse,
                        output logic [W-1:0] dat);
    is_input_valid = 1'b1; mem_read = rd; mem_write = wr; addr = a; din = d;
    @(negedge clk);
    is_input_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    busy = 0;
    while (!mem_ready && busy < 100) begin
      busy++;
      @(negedge clk);
    end
    pulse = is_output_valid;
    dat   = dout;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int           busy;
    int           n;
    logic         pulse;
    logic [W-1:0] dat;
    logic [W-1:0] a5, x1, x2, x3;
    int           pulses[$];
    a5 = {16{8'hA5}};
    x1 = {16{8'h07}};
    x2 = {16{8'h08}};
    x3 = {16{8'h55}};

    reset = 1'b1; is_input_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    addr = '0; din = '0;
    repeat (2) @(negedge clk);
    check_i("rst_ready", int'(mem_ready), 1);
    check_i("rst_valid", int'(is_output_valid), 0);
    check_v("rst_dout", dout, '0);
    reset = 1'b0;

    // 1: read of never-written line
    do_req(1'b1, 1'b0, 32'd5, '0, busy, pulse, dat);
    check_i("t1_busy_cycles", busy, 4);
    check_i("t1_pulse", int'(pulse), 1);
    check_v("t1_dout", dat, '0);

    // 2: write then read back
    do_req(1'b0, 1'b1, 32'd3, a5, busy, pulse, dat);
    check_i("t2_wr_busy", busy, 4);
    check_i("t2_wr_no_pulse", int'(pulse), 0);
    do_req(1'b1, 1'b0, 32'd3, '0, busy, pulse, dat);
    check_v("t2_rd_dout", dat, a5);

    // 3: aliased write overwrites line 3
    do_req(1'b0, 1'b1, 32'd3 + 32'(NL), 128'h1, busy, pulse, dat);
    check_v("t3_wr_keeps_dout", dat, a5);
    do_req(1'b1, 1'b0, 32'd3, '0, busy, pulse, dat);
    check_v("t3_alias_dout", dat, 128'h1);

    // 4: malformed request held for 10 cycles
    is_input_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b1; addr = 32'd3; din = '1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_i("t4_ready", int'(mem_ready), 1);
      check_i("t4_no_pulse", int'(is_output_valid), 0);
    end
    is_input_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    do_req(1'b1, 1'b0, 32'd3, '0, busy, pulse, dat);
    check_i("t4_rd_busy", busy, 4);
    check_v("t4_rd_dout", dat, 128'h1);

    // 5: held read of line 7, inputs scrambled while busy
    do_req(1'b0, 1'b1, 32'd7, x1, busy, pulse, dat);
    do_req(1'b0, 1'b1, 32'd8, x2, busy, pulse, dat);
    for (int c = 0; c < 22; c++) begin
      is_input_valid = 1'b1;
      if (mem_ready) begin
        mem_read = 1'b1; mem_write = 1'b0; addr = 32'd7; din = '0;
      end else begin
        mem_read = 1'b0; mem_write = 1'b1; addr = 32'd8; din = '1;
      end
      @(negedge clk);
      if (is_output_valid) begin
        pulses.push_back(c);
        check_v("t5_dout", dout, x1);
      end
    end
    is_input_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    check_i("t5_pulse_count", pulses.size(), 4);
    for (int i = 0; i < pulses.size(); i++)
      check_i("t5_pulse_at", pulses[i], 4 + 5 * i);
    n = 0;
    while (!mem_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    check_i("t5_drain_ok", int'(n < 100), 1);
    do_req(1'b1, 1'b0, 32'd8, '0, busy, pulse, dat);
    check_v("t5_line8_intact", dat, x2);

    // 6: reset during an in-flight write
    do_req(1'b0, 1'b1, 32'd9, x3, busy, pulse, dat);
    is_input_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; addr = 32'd9;
    din = {{(W-8){1'b0}}, 8'hFF};
    @(negedge clk);
    is_input_valid = 1'b0; mem_write = 1'b0;
    check_i("t6_busy", int'(mem_ready), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_i("t6_rst_ready", int'(mem_ready), 1);
    check_v("t6_rst_dout", dout, '0);
    check_i("t6_rst_no_pulse", int'(is_output_valid), 0);
    reset = 1'b0;
    do_req(1'b1, 1'b0, 32'd9, '0, busy, pulse, dat);
    check_i("t6_rd_pulse", int'(pulse), 1);
    check_v("t6_write_dropped", dat, x3);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
